// File: rtl/multicycle_controller_if.sv
// -----------------------------------------------------------------------------
// multicycle_controller_if
// Memory handshake between the multicycle controller and the shared
// instruction/data memory port.
//   mem_req   : controller requests an access this cycle
//   memwrite  : store strobe, only meaningful while mem_req is high
//   mem_ready : memory completes the current access this cycle
// Modports: master (controller side), slave (memory side).
// -----------------------------------------------------------------------------
interface multicycle_controller_if;
    logic mem_req;
    logic memwrite;
    logic mem_ready;

    modport master (output mem_req, output memwrite, input mem_ready);
    modport slave  (input mem_req, input memwrite, output mem_ready);
endinterface

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
// Control FSM for the RV32I multicycle datapath (shared ALU, single memory
// port, register file, immediate extender). Handles variable-latency memory
// through a req/ready handshake and runs a wait-cycle watchdog on each access.
//
// Parameters:
//   MAX_WAIT : wait cycles before mem_timeout is flagged (0 disables)
//   WAIT_W   : wait counter width, MAX_WAIT < 2**WAIT_W
//
// Ports:
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   mem               : memory handshake (mem_req, memwrite, mem_ready)
//   op/funct3/funct7b5: instruction fields from the instruction register
//   zero              : ALU zero flag
//   adrsrc, irwrite, pcwrite, regwrite, alusrca, alusrcb, resultsrc,
//   immsrc, alucontrol: datapath controls
//   mem_timeout       : sticky watchdog flag
//   illegal           : illegal-opcode flag
//   state_o           : current state, for debug
//
// Build option: define ILLEGAL_TRAP_EN to trap unknown opcodes in TRAP (12)
// with illegal=1; otherwise unknown opcodes retire as a NOP.
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    multicycle_controller_if.master        mem,
    input  logic [6:0]                     op,
    input  logic [2:0]                     funct3,
    input  logic                           funct7b5,
    input  logic                           zero,
    output logic                           adrsrc,
    output logic                           irwrite,
    output logic                           pcwrite,
    output logic                           regwrite,
    output logic [1:0]                     alusrca,
    output logic [1:0]                     alusrcb,
    output logic [1:0]                     resultsrc,
    output logic [2:0]                     immsrc,
    output logic [2:0]                     alucontrol,
    output logic                           mem_timeout,
    output logic                           illegal,
    output logic [3:0]                     state_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Controls that depend only on the state; registered from the next state
    // so they come straight off flops.
    typedef struct packed {
        logic       mem_req;
        logic       memwrite;
        logic       adrsrc;
        logic       regwrite;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
    } moore_t;

    function automatic moore_t moore_decode(input state_t s);
        moore_t m;
        m = '0;
        case (s)
            S_FETCH: begin
                m.mem_req   = 1'b1;
                m.alusrcb   = 2'b10;
                m.resultsrc = 2'b10;
            end
            S_DECODE: begin
                m.alusrca = 2'b01;
                m.alusrcb = 2'b01;
            end
            S_MEMADR, S_EXECI: begin
                m.alusrca = 2'b10;
                m.alusrcb = 2'b01;
            end
            S_MEMREAD: begin
                m.mem_req = 1'b1;
                m.adrsrc  = 1'b1;
            end
            S_MEMWB: begin
                m.resultsrc = 2'b01;
                m.regwrite  = 1'b1;
            end
            S_MEMWRITE: begin
                m.mem_req  = 1'b1;
                m.memwrite = 1'b1;
                m.adrsrc   = 1'b1;
            end
            S_EXECR, S_BRANCH: begin
                m.alusrca = 2'b10;
            end
            S_ALUWB: begin
                m.regwrite = 1'b1;
            end
            S_JAL: begin
                m.alusrca = 2'b01;
                m.alusrcb = 2'b10;
            end
            S_LUI: begin
                m.alusrca = 2'b11;
                m.alusrcb = 2'b01;
            end
            default: ;
        endcase
        return m;
    endfunction

    // funct7b5 only selects sub for R-type; addi with instr[30] set still adds.
    function automatic logic [2:0] alu_decode(input logic [2:0] f3,
                                              input logic       is_rtype,
                                              input logic       f7b5);
        logic [2:0] ctl;
        case (f3)
            3'b000:  ctl = (is_rtype && f7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  ctl = ALU_SLT;
            3'b100:  ctl = ALU_XOR;
            3'b110:  ctl = ALU_OR;
            3'b111:  ctl = ALU_AND;
            default: ctl = ALU_ADD;
        endcase
        return ctl;
    endfunction

    state_t              state_q, state_d;
    moore_t              moore_q, moore_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                mem_timeout_q, mem_timeout_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BR:             state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_LUI:            state_d = S_LUI;
`ifdef ILLEGAL_TRAP_EN
                    default:           state_d = S_TRAP;
`else
                    default:           state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem.mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem.mem_ready) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_LUI:      state_d = S_ALUWB;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
        moore_d = moore_decode(state_d);
    end

    // Watchdog: counts stalled request cycles, saturates at all-ones so it
    // never wraps back below MAX_WAIT, and latches the timeout flag.
    always_comb begin
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        if (mem.mem_ready) begin
            wait_cnt_d = '0;
        end else if (moore_q.mem_req && (wait_cnt_q != '1)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
        if ((MAX_WAIT != 0) && (wait_cnt_d == WAIT_W'(MAX_WAIT))) begin
            mem_timeout_d = 1'b1;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
    assign illegal_d = (state_d == S_TRAP);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_FETCH;
            moore_q       <= moore_decode(S_FETCH);
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            moore_q       <= moore_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
`ifdef ILLEGAL_TRAP_EN
            illegal_q     <= illegal_d;
`endif
        end
    end

    // Everything is gated by rst_n so an asserted reset drops a pending store
    // immediately instead of waiting for the flops.
    always_comb begin
        mem.mem_req  = 1'b0;
        mem.memwrite = 1'b0;
        adrsrc       = 1'b0;
        irwrite      = 1'b0;
        pcwrite      = 1'b0;
        regwrite     = 1'b0;
        alusrca      = 2'b00;
        alusrcb      = 2'b00;
        resultsrc    = 2'b00;
        immsrc       = 3'b000;
        alucontrol   = ALU_ADD;
        mem_timeout  = 1'b0;
        if (rst_n) begin
            mem.mem_req  = moore_q.mem_req;
            mem.memwrite = moore_q.memwrite;
            adrsrc       = moore_q.adrsrc;
            regwrite     = moore_q.regwrite;
            alusrca      = moore_q.alusrca;
            alusrcb      = moore_q.alusrcb;
            resultsrc    = moore_q.resultsrc;
            mem_timeout  = mem_timeout_q;
            irwrite      = (state_q == S_FETCH) && mem.mem_ready;
            case (state_q)
                S_FETCH:  pcwrite = mem.mem_ready;
                S_JAL:    pcwrite = 1'b1;
                S_BRANCH: begin
                    case (funct3)
                        3'b000:  pcwrite = zero;
                        3'b001:  pcwrite = ~zero;
                        default: pcwrite = 1'b0;
                    endcase
                end
                default:  pcwrite = 1'b0;
            endcase
            // The immediate select and ALU op follow the instruction fields,
            // which are only valid after IR is loaded, so they stay combinational.
            case (state_q)
                S_DECODE: immsrc = (op == OP_JAL) ? 3'b011 : 3'b010;
                S_MEMADR: immsrc = (op == OP_STORE) ? 3'b001 : 3'b000;
                S_LUI:    immsrc = 3'b100;
                default:  immsrc = 3'b000;
            endcase
            case (state_q)
                S_EXECR, S_EXECI: alucontrol = alu_decode(funct3, op == OP_RTYPE, funct7b5);
                S_BRANCH:         alucontrol = ALU_SUB;
                default:          alucontrol = ALU_ADD;
            endcase
        end
    end

`ifdef ILLEGAL_TRAP_EN
    assign illegal = rst_n && illegal_q;
`else
    assign illegal = 1'b0;
`endif

    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
// Directed bench for multicycle_controller (MAX_WAIT=4). Each vector drives
// the instruction fields, zero and mem_ready for one clock and lists every
// control output expected in that cycle.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       adrsrc, irwrite, pcwrite, regwrite;
    logic [1:0] alusrca, alusrcb, resultsrc;
    logic [2:0] immsrc, alucontrol;
    logic       mem_timeout, illegal;
    logic [3:0] state_o;

    always #5 clk = ~clk;

    multicycle_controller_if mem_if();

    multicycle_controller #(.MAX_WAIT(4), .WAIT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem        (mem_if),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .adrsrc     (adrsrc),
        .irwrite    (irwrite),
        .pcwrite    (pcwrite),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .resultsrc  (resultsrc),
        .immsrc     (immsrc),
        .alucontrol (alucontrol),
        .mem_timeout(mem_timeout),
        .illegal    (illegal),
        .state_o    (state_o)
    );

    typedef struct packed {
        logic [3:0] state;
        logic       mem_req;
        logic       memwrite;
        logic       adrsrc;
        logic       irwrite;
        logic       pcwrite;
        logic       regwrite;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic [2:0] immsrc;
        logic [2:0] alucontrol;
        logic       mem_timeout;
        logic       illegal;
    } outs_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       zero;
        logic       rdy;
        outs_t      exp;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    // Argument order: state, mem_req, memwrite, adrsrc, irwrite, pcwrite,
    // regwrite, alusrca, alusrcb, resultsrc, immsrc, alucontrol, timeout, illegal
    function automatic outs_t e(input int st, input int rq, input int mw, input int ad,
                                input int ir, input int pc, input int rw, input int a,
                                input int b, input int res, input int imm, input int alu,
                                input int to, input int il);
        outs_t o;
        o.state       = 4'(st);
        o.mem_req     = 1'(rq);
        o.memwrite    = 1'(mw);
        o.adrsrc      = 1'(ad);
        o.irwrite     = 1'(ir);
        o.pcwrite     = 1'(pc);
        o.regwrite    = 1'(rw);
        o.alusrca     = 2'(a);
        o.alusrcb     = 2'(b);
        o.resultsrc   = 2'(res);
        o.immsrc      = 3'(imm);
        o.alucontrol  = 3'(alu);
        o.mem_timeout = 1'(to);
        o.illegal     = 1'(il);
        return o;
    endfunction

    function automatic vec_t mkVec(input logic [6:0] op_i, input int f3, input int f7,
                                   input int z, input int rdy, input outs_t ex);
        vec_t v;
        v.op   = op_i;
        v.f3   = 3'(f3);
        v.f7   = 1'(f7);
        v.zero = 1'(z);
        v.rdy  = 1'(rdy);
        v.exp  = ex;
        return v;
    endfunction

    function automatic void addVec(input logic [6:0] op_i, input int f3, input int f7,
                                   input int z, input int rdy, input outs_t ex);
        vecs.push_back(mkVec(op_i, f3, f7, z, rdy, ex));
    endfunction

    function automatic outs_t sampleOutputs();
        outs_t o;
        o.state       = state_o;
        o.mem_req     = mem_if.mem_req;
        o.memwrite    = mem_if.memwrite;
        o.adrsrc      = adrsrc;
        o.irwrite     = irwrite;
        o.pcwrite     = pcwrite;
        o.regwrite    = regwrite;
        o.alusrca     = alusrca;
        o.alusrcb     = alusrcb;
        o.resultsrc   = resultsrc;
        o.immsrc      = immsrc;
        o.alucontrol  = alucontrol;
        o.mem_timeout = mem_timeout;
        o.illegal     = illegal;
        return o;
    endfunction

    task automatic checkOutput(input string name, input outs_t exp);
        outs_t act;
        act = sampleOutputs();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h (state %0d) required %h (state %0d)",
                     name, act, act.state, exp, exp.state);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input string name);
        op               = v.op;
        funct3           = v.f3;
        funct7b5         = v.f7;
        zero             = v.zero;
        mem_if.mem_ready = v.rdy;
        @(negedge clk);
        checkOutput(name, v.exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        outs_t fetchGo, fetchWait, decB, aluWb, allZero, after;

        rst_n            = 1'b0;
        op               = OP_I;
        funct3           = 3'd0;
        funct7b5         = 1'b0;
        zero             = 1'b0;
        mem_if.mem_ready = 1'b1;

        fetchGo   = e(0, 1,0,0,1,1,0, 0,2,2, 0,0, 0,0);
        fetchWait = e(0, 1,0,0,0,0,0, 0,2,2, 0,0, 0,0);
        decB      = e(1, 0,0,0,0,0,0, 1,1,0, 2,0, 0,0);
        aluWb     = e(8, 0,0,0,0,0,1, 0,0,0, 0,0, 0,0);
        allZero   = e(0, 0,0,0,0,0,0, 0,0,0, 0,0, 0,0);

        // addi with instr[30] set still adds
        addVec(OP_I, 0, 1, 0, 1, fetchGo);
        addVec(OP_I, 0, 1, 0, 1, decB);
        addVec(OP_I, 0, 1, 0, 1, e(7, 0,0,0,0,0,0, 2,1,0, 0,0, 0,0));
        addVec(OP_I, 0, 1, 0, 1, aluWb);
        // sub
        addVec(OP_R, 0, 1, 0, 1, fetchGo);
        addVec(OP_R, 0, 1, 0, 1, decB);
        addVec(OP_R, 0, 1, 0, 1, e(6, 0,0,0,0,0,0, 2,0,0, 0,1, 0,0));
        addVec(OP_R, 0, 1, 0, 1, aluWb);
        // slt
        addVec(OP_R, 2, 0, 0, 1, fetchGo);
        addVec(OP_R, 2, 0, 0, 1, decB);
        addVec(OP_R, 2, 0, 0, 1, e(6, 0,0,0,0,0,0, 2,0,0, 0,5, 0,0));
        addVec(OP_R, 2, 0, 0, 1, aluWb);
        // xori
        addVec(OP_I, 4, 0, 0, 1, fetchGo);
        addVec(OP_I, 4, 0, 0, 1, decB);
        addVec(OP_I, 4, 0, 0, 1, e(7, 0,0,0,0,0,0, 2,1,0, 0,4, 0,0));
        addVec(OP_I, 4, 0, 0, 1, aluWb);
        // or
        addVec(OP_R, 6, 0, 0, 1, fetchGo);
        addVec(OP_R, 6, 0, 0, 1, decB);
        addVec(OP_R, 6, 0, 0, 1, e(6, 0,0,0,0,0,0, 2,0,0, 0,3, 0,0));
        addVec(OP_R, 6, 0, 0, 1, aluWb);
        // andi
        addVec(OP_I, 7, 1, 0, 1, fetchGo);
        addVec(OP_I, 7, 1, 0, 1, decB);
        addVec(OP_I, 7, 1, 0, 1, e(7, 0,0,0,0,0,0, 2,1,0, 0,2, 0,0));
        addVec(OP_I, 7, 1, 0, 1, aluWb);
        // sll falls into the add default
        addVec(OP_R, 1, 0, 0, 1, fetchGo);
        addVec(OP_R, 1, 0, 0, 1, decB);
        addVec(OP_R, 1, 0, 0, 1, e(6, 0,0,0,0,0,0, 2,0,0, 0,0, 0,0));
        addVec(OP_R, 1, 0, 0, 1, aluWb);
        // sw: two fetch wait states, one store wait state
        addVec(OP_SW, 2, 0, 0, 0, fetchWait);
        addVec(OP_SW, 2, 0, 0, 0, fetchWait);
        addVec(OP_SW, 2, 0, 0, 1, fetchGo);
        addVec(OP_SW, 2, 0, 0, 1, decB);
        addVec(OP_SW, 2, 0, 0, 1, e(2, 0,0,0,0,0,0, 2,1,0, 1,0, 0,0));
        addVec(OP_SW, 2, 0, 0, 0, e(5, 1,1,1,0,0,0, 0,0,0, 0,0, 0,0));
        addVec(OP_SW, 2, 0, 0, 1, e(5, 1,1,1,0,0,0, 0,0,0, 0,0, 0,0));
        // beq taken
        addVec(OP_B, 0, 0, 1, 1, fetchGo);
        addVec(OP_B, 0, 0, 1, 1, decB);
        addVec(OP_B, 0, 0, 1, 1, e(9, 0,0,0,0,1,0, 2,0,0, 0,1, 0,0));
        // bne with zero=1: not taken
        addVec(OP_B, 1, 0, 1, 1, fetchGo);
        addVec(OP_B, 1, 0, 1, 1, decB);
        addVec(OP_B, 1, 0, 1, 1, e(9, 0,0,0,0,0,0, 2,0,0, 0,1, 0,0));
        // bne with zero=0: taken
        addVec(OP_B, 1, 0, 0, 1, fetchGo);
        addVec(OP_B, 1, 0, 0, 1, decB);
        addVec(OP_B, 1, 0, 0, 1, e(9, 0,0,0,0,1,0, 2,0,0, 0,1, 0,0));
        // blt never writes PC
        addVec(OP_B, 4, 0, 1, 1, fetchGo);
        addVec(OP_B, 4, 0, 1, 1, decB);
        addVec(OP_B, 4, 0, 1, 1, e(9, 0,0,0,0,0,0, 2,0,0, 0,1, 0,0));
        // jal
        addVec(OP_JAL, 0, 0, 0, 1, fetchGo);
        addVec(OP_JAL, 0, 0, 0, 1, e(1, 0,0,0,0,0,0, 1,1,0, 3,0, 0,0));
        addVec(OP_JAL, 0, 0, 0, 1, e(10, 0,0,0,0,1,0, 1,2,0, 0,0, 0,0));
        addVec(OP_JAL, 0, 0, 0, 1, aluWb);
        // lui
        addVec(OP_LUI, 0, 0, 0, 1, fetchGo);
        addVec(OP_LUI, 0, 0, 0, 1, decB);
        addVec(OP_LUI, 0, 0, 0, 1, e(11, 0,0,0,0,0,0, 3,1,0, 4,0, 0,0));
        addVec(OP_LUI, 0, 0, 0, 1, aluWb);
        // lw with three read wait states: 8 cycles total
        addVec(OP_LW, 2, 0, 0, 1, fetchGo);
        addVec(OP_LW, 2, 0, 0, 1, decB);
        addVec(OP_LW, 2, 0, 0, 1, e(2, 0,0,0,0,0,0, 2,1,0, 0,0, 0,0));
        for (int k = 0; k < 3; k++)
            addVec(OP_LW, 2, 0, 0, 0, e(3, 1,0,1,0,0,0, 0,0,0, 0,0, 0,0));
        addVec(OP_LW, 2, 0, 0, 1, e(3, 1,0,1,0,0,0, 0,0,0, 0,0, 0,0));
        addVec(OP_LW, 2, 0, 0, 1, e(4, 0,0,0,0,0,1, 0,0,1, 0,0, 0,0));

        // In reset with mem_ready high: everything forced low
        @(negedge clk);
        checkOutput("in reset", allZero);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (vecs[i])
            applyStimulus(vecs[i], $sformatf("table[%0d]", i));

        // Watchdog: flag appears once four wait cycles have elapsed, then sticks
        for (int j = 1; j <= 6; j++)
            applyStimulus(mkVec(OP_SW, 2, 0, 0, 0,
                                e(0, 1,0,0,0,0,0, 0,2,2, 0,0, (j >= 5) ? 1 : 0, 0)),
                          $sformatf("watchdog wait %0d", j));
        applyStimulus(mkVec(OP_SW, 2, 0, 0, 1, e(0, 1,0,0,1,1,0, 0,2,2, 0,0, 1,0)), "watchdog fetch done");
        applyStimulus(mkVec(OP_SW, 2, 0, 0, 1, e(1, 0,0,0,0,0,0, 1,1,0, 2,0, 1,0)), "watchdog sticky decode");
        applyStimulus(mkVec(OP_SW, 2, 0, 0, 1, e(2, 0,0,0,0,0,0, 2,1,0, 1,0, 1,0)), "sw memadr");
        applyStimulus(mkVec(OP_SW, 2, 0, 0, 0, e(5, 1,1,1,0,0,0, 0,0,0, 0,0, 1,0)), "sw store waiting");

        // Reset in the middle of the pending store
        rst_n = 1'b0;
        #1;
        checkOutput("reset mid-sw", allZero);
        @(negedge clk);
        checkOutput("reset held", allZero);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Unknown opcode
        applyStimulus(mkVec(OP_BAD, 0, 0, 0, 1, fetchGo), "bad op fetch");
        applyStimulus(mkVec(OP_BAD, 0, 0, 0, 1, decB), "bad op decode");
`ifdef ILLEGAL_TRAP_EN
        after = e(12, 0,0,0,0,0,0, 0,0,0, 0,0, 0,1);
`else
        after = fetchWait;
`endif
        for (int k = 0; k < 3; k++)
            applyStimulus(mkVec(OP_BAD, 0, 0, 0, 0, after), $sformatf("after bad op %0d", k));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore/Mealy control FSM that sequences the RV32I multicycle datapath: shared ALU, single instruction/data memory port, register file and immediate extender.
- Drives the extender's immsrc encoding: 000 I, 001 S, 010 B, 011 J, 100 U.
- Handles variable-latency memory with a req/ready handshake.
- Runs a wait-cycle watchdog on each memory access.

Parameters:
- MAX_WAIT, 15: memory wait cycles before mem_timeout is flagged. 0 disables the watchdog.
- WAIT_W, 8: width of the wait counter. Must satisfy MAX_WAIT < 2**WAIT_W.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- op  in  7  instr[6:0] from the instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- memwrite  out  1  store strobe, qualified by mem_req
- adrsrc  out  1  memory address select: 0 PC, 1 ALUOut
- irwrite  out  1  latch instruction and oldPC
- pcwrite  out  1  PC <= result
- regwrite  out  1  register file write
- alusrca  out  2  00 PC, 01 oldPC, 10 rd1, 11 zero
- alusrcb  out  2  00 rd2, 01 immext, 10 const 4
- resultsrc  out  2  00 ALUOut, 01 readdata, 10 ALUResult
- immsrc  out  3  extender select, encoding as above
- alucontrol  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
- mem_timeout  out  1  sticky watchdog flag
- illegal  out  1  illegal-opcode flag (see Optional Feature)
- state_o  out  4  current state, for debug

Behaviour:
- Reset: state <= FETCH; wait counter, mem_timeout and illegal <= 0.
  - While rst_n=0, all enables, mem_req and flags are forced to 0; all mux selects are 0.
  - The first fetch request is in the first cycle after deassertion.
  - Reset mid-instruction aborts it; a partially issued store is dropped.
- Outputs not listed for a state are 0.
- FETCH (0): mem_req=1, adrsrc=0, alusrca=00, alusrcb=10, add, resultsrc=10.
  - irwrite=pcwrite=mem_ready.
  - Next state: DECODE if mem_ready, else FETCH.
- DECODE (1): alusrca=01, alusrcb=01, add. immsrc=011 if op=1101111, else 010.
  - Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 0110111 -> LUI
    - others -> FETCH
- MEMADR (2): alusrca=10, alusrcb=01, add. immsrc=001 for stores, 000 for loads.
  - Next state: MEMREAD for loads, MEMWRITE for stores.
- MEMREAD (3): mem_req=1, adrsrc=1. Holds until mem_ready, then -> MEMWB.
- MEMWB (4): resultsrc=01, regwrite=1 -> FETCH.
- MEMWRITE (5): mem_req=memwrite=1, adrsrc=1, both held stable while waiting. On mem_ready -> FETCH.
- EXECR (6): alusrca=10, alusrcb=00, ALU decode -> ALUWB.
- EXECI (7): alusrca=10, alusrcb=01, immsrc=000, ALU decode -> ALUWB.
- ALUWB (8): resultsrc=00, regwrite=1 -> FETCH.
- BRANCH (9): alusrca=10, alusrcb=00, sub, resultsrc=00 -> FETCH.
  - pcwrite = zero when funct3=000, ~zero when funct3=001, 0 for other funct3.
- JAL (10): alusrca=01, alusrcb=10, add, resultsrc=00, pcwrite=1 -> ALUWB.
- LUI (11): alusrca=11, alusrcb=01, immsrc=100, add -> ALUWB.
- ALU decode by funct3:
  - 000: sub only if op=0110011 and funct7b5=1, else add
  - 010: slt
  - 100: xor
  - 110: or
  - 111: and
  - others: add
- Latency with zero wait states: lw 5 cycles; sw, R, I, jal and lui 4; branch 3. Each mem_ready=0 cycle adds 1.
- Watchdog: the counter increments each cycle mem_req=1 and mem_ready=0, and clears when mem_ready=1.
  - When the count reaches MAX_WAIT (if MAX_WAIT≠0), mem_timeout sets and stays set until reset.
  - The FSM keeps waiting after the flag sets.
  - The counter saturates and does not wrap.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an unlisted op in DECODE -> TRAP (12).
  - In TRAP all enables and mem_req are 0, illegal=1, and the FSM stays there until reset.
- Undefined: an unlisted op returns to FETCH with no write (NOP). illegal is tied 0 and state 12 is unreachable.

Test Plan:
- Release reset with mem_ready=1 and op=0010011 (addi) -> irwrite=pcwrite=1 in cycle 1; state_o sequence 0,1,7,8,0; regwrite=1 only in cycle 4 with immsrc=000 in EXECI.
- lw with mem_ready low for 3 cycles in MEMREAD -> state stays 3 for 3 extra cycles and mem_req stays 1; lw totals 8 cycles.
- beq with zero=1, then bne with zero=1 -> pcwrite=1 for beq, pcwrite=0 for bne; each takes 3 cycles; DECODE immsrc=010.
- jal then lui -> DECODE immsrc=011 for jal; jal path 0,1,10,8; lui EXECI-equivalent shows immsrc=100 with alusrca=11.
- MAX_WAIT=4, mem_ready held 0 in FETCH for 6 cycles -> mem_timeout rises on the 4th wait cycle and stays 1 after mem_ready returns.
- op=1111111 -> with ILLEGAL_TRAP_EN: state_o=12, illegal=1, no further mem_req; without it: back to FETCH, illegal=0. Assert rst_n=0 mid-sw: memwrite drops immediately.
